axis_pgroup_sender: RTL and testbench

AXI-Stream master that turns a flat stream of pixel groups into routed AXI-Stream frames for the image-processor array. It sits between the frame-fetch read path and the AXI-Stream interconnect, and it mirrors the receiving controller on the far side. Each frame carries a TID from a wrapping frame counter. TDEST rotates round-robin across image processors in fixed-length bursts. TLAST marks every burst end. A registered output slice isolates `m_tready_i` from the upstream handshake.

---
 rtl/axis_pkg.sv | 22 ++
 rtl/axis_out_slice.sv | 76 +++++++
 rtl/axis_pgroup_sender.sv | 168 ++++++++++++++++
 tb/tb_axis_pgroup_sender.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream pixel-group sender: FSM encoding,
// byte-qualifier constant and width helpers.
package axis_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_e;

   // Every byte lane of a pixel group is valid data
   localparam logic AXIS_BYTE_ON = 1'b1;

   function automatic int unsigned tdest_width(input int unsigned addr_w);
      return (addr_w > 1) ? addr_w : 1;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axis_out_slice.sv
// Two-entry registered output slice; the upstream side sees only registered state.
module axis_out_slice #(
   parameter int unsigned PAYLOAD_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [PAYLOAD_W-1:0] s_payload_i,
   input  logic                 s_push_i,
   output logic [PAYLOAD_W-1:0] m_payload_o,
   output logic                 m_valid_o,
   input  logic                 m_ready_i,
   output logic [1:0]           level_nxt_c_o
);

   logic [PAYLOAD_W-1:0] head_q, head_d;
   logic [PAYLOAD_W-1:0] tail_q, tail_d;
   logic [1:0]           level_q, level_d;
   logic                 valid_q, valid_d;
   logic                 pop_c;

   // Head register drives the master channel; tail catches a beat while the head stalls
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      level_d = level_q;
      pop_c   = valid_q & m_ready_i;
      case ({s_push_i, pop_c})
         2'b10: begin
            if (level_q == 2'd0) begin
               head_d  = s_payload_i;
               level_d = 2'd1;
            end else begin
               tail_d  = s_payload_i;
               level_d = 2'd2;
            end
         end
         2'b01: begin
            if (level_q == 2'd2) begin
               head_d  = tail_q;
               level_d = 2'd1;
            end else begin
               level_d = 2'd0;
            end
         end
         2'b11: begin
            if (level_q == 2'd2) begin
               head_d = tail_q;
               tail_d = s_payload_i;
            end else begin
               head_d = s_payload_i;
            end
         end
         default: ;
      endcase
      valid_d = (level_d != 2'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         level_q <= 2'd0;
         valid_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         level_q <= level_d;
         valid_q <= valid_d;
      end
   end

   assign m_payload_o   = head_q;
   assign m_valid_o     = valid_q;
   assign level_nxt_c_o = level_d;

endmodule

// File: rtl/axis_pgroup_sender.sv
// Frames a pixel-group stream into routed AXI-Stream bursts with a wrapping TID.
// Optional stall counter built when AXIS_PGROUP_SENDER_STATS_EN is defined.
module axis_pgroup_sender
   import axis_pkg::*;
#(
   parameter int unsigned IP_AMT       = 1,
   parameter int unsigned IP_ADDR_W    = $clog2(IP_AMT),
   parameter int unsigned IP_DATA_W    = 256,
   parameter int unsigned AXIS_TID_W   = 2,
   parameter int unsigned AXIS_TDEST_W = tdest_width(IP_ADDR_W),
   parameter int unsigned AXIS_TDATA_W = IP_DATA_W,
   parameter int unsigned AXIS_TKEEP_W = AXIS_TDATA_W / 8,
   parameter int unsigned AXIS_TSTRB_W = AXIS_TDATA_W / 8,
   parameter int unsigned FRAME_BEATS  = 1200,
   parameter int unsigned BEATS_PER_IP = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_i,
   output logic                    busy_o,
   input  logic [IP_DATA_W-1:0]    pgroup_i,
   input  logic                    pgroup_valid_i,
   output logic                    pgroup_ready_o,
   output logic [AXIS_TID_W-1:0]   m_tid_o,
   output logic [AXIS_TDEST_W-1:0] m_tdest_o,
   output logic [AXIS_TDATA_W-1:0] m_tdata_o,
   output logic [AXIS_TKEEP_W-1:0] m_tkeep_o,
   output logic [AXIS_TSTRB_W-1:0] m_tstrb_o,
   output logic                    m_tlast_o,
   output logic                    m_tvalid_o,
   input  logic                    m_tready_i
`ifdef AXIS_PGROUP_SENDER_STATS_EN
   ,
   output logic [31:0]             stall_cnt_o
`endif
);

   localparam int unsigned BEAT_W    = cnt_width(FRAME_BEATS);
   localparam int unsigned BURST_W   = cnt_width(BEATS_PER_IP);
   localparam int unsigned PAYLOAD_W = AXIS_TID_W + AXIS_TDEST_W + 1 + AXIS_TDATA_W;

   state_e                  state_q, state_d;
   logic [BEAT_W-1:0]       beat_q, beat_d;
   logic [BURST_W-1:0]      burst_q, burst_d;
   logic [AXIS_TDEST_W-1:0] dest_q, dest_d;
   logic [AXIS_TID_W-1:0]   frame_id_q, frame_id_d;
   logic                    ready_q, ready_d;
   logic                    busy_q, busy_d;

   logic                    accept_c;
   logic                    last_beat_c;
   logic                    tlast_c;
   logic                    start_ok_c;
   logic [PAYLOAD_W-1:0]    slice_in;
   logic [PAYLOAD_W-1:0]    slice_out;
   logic [1:0]              level_nxt;

   // Next-state logic for FSM, counters and the registered handshake flags
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      burst_d     = burst_q;
      dest_d      = dest_q;
      frame_id_d  = frame_id_q;
      accept_c    = pgroup_valid_i & ready_q;
      last_beat_c = (beat_q == BEAT_W'(FRAME_BEATS - 1));
      tlast_c     = (burst_q == BURST_W'(BEATS_PER_IP - 1)) | last_beat_c;
      start_ok_c  = start_i & ~busy_q;

      case (state_q)
         ST_IDLE: begin
            if (start_ok_c) begin
               state_d = ST_STREAM;
               beat_d  = '0;
               burst_d = '0;
               dest_d  = '0;
            end
         end
         ST_STREAM: begin
            if (accept_c) begin
               beat_d  = last_beat_c ? '0 : beat_q + BEAT_W'(1);
               burst_d = tlast_c ? '0 : burst_q + BURST_W'(1);
               if (tlast_c) begin
                  dest_d = (dest_q == AXIS_TDEST_W'(IP_AMT - 1)) ? '0
                                                                 : dest_q + AXIS_TDEST_W'(1);
               end
               if (last_beat_c) begin
                  state_d    = ST_IDLE;
                  frame_id_d = frame_id_q + AXIS_TID_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Ready and busy look one cycle ahead so both can be plain flops
      ready_d = (state_d == ST_STREAM) & (level_nxt != 2'd2);
      busy_d  = (state_d == ST_STREAM) | (level_nxt != 2'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         beat_q     <= '0;
         burst_q    <= '0;
         dest_q     <= '0;
         frame_id_q <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         burst_q    <= burst_d;
         dest_q     <= dest_d;
         frame_id_q <= frame_id_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
      end
   end

   assign slice_in = {frame_id_q, dest_q, tlast_c, AXIS_TDATA_W'(pgroup_i)};

   axis_out_slice #(
      .PAYLOAD_W (PAYLOAD_W)
   ) u_out_slice (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_payload_i   (slice_in),
      .s_push_i      (accept_c),
      .m_payload_o   (slice_out),
      .m_valid_o     (m_tvalid_o),
      .m_ready_i     (m_tready_i),
      .level_nxt_c_o (level_nxt)
   );

   assign {m_tid_o, m_tdest_o, m_tlast_o, m_tdata_o} = slice_out;
   assign m_tkeep_o      = {AXIS_TKEEP_W{AXIS_BYTE_ON}};
   assign m_tstrb_o      = {AXIS_TSTRB_W{AXIS_BYTE_ON}};
   assign pgroup_ready_o = ready_q;
   assign busy_o         = busy_q;

`ifdef AXIS_PGROUP_SENDER_STATS_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles the downstream holds off a valid beat
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (start_ok_c) begin
         stall_cnt_d = '0;
      end else if (m_tvalid_o & ~m_tready_i & (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   // No stall statistics in this build
`endif

endmodule

// File: tb/tb_axis_pgroup_sender.sv
// Self-checking bench for axis_pgroup_sender: scenario table plus hand-written
// reset and stall sequences, checked against a frame-level reference model.
module tb_axis_pgroup_sender;

   localparam int unsigned IPA  = 4;
   localparam int unsigned BPI  = 2;
   localparam int unsigned FB   = 9;
   localparam int unsigned DW   = 32;
   localparam int unsigned TIDW = 2;
   localparam int unsigned TDW  = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start_i;
   logic            busy_o;
   logic [DW-1:0]   pgroup_i;
   logic            pgroup_valid_i;
   logic            pgroup_ready_o;
   logic [TIDW-1:0] m_tid_o;
   logic [TDW-1:0]  m_tdest_o;
   logic [DW-1:0]   m_tdata_o;
   logic [DW/8-1:0] m_tkeep_o;
   logic [DW/8-1:0] m_tstrb_o;
   logic            m_tlast_o;
   logic            m_tvalid_o;
   logic            m_tready_i;
`ifdef AXIS_PGROUP_SENDER_STATS_EN
   logic [31:0]     stall_cnt_o;
`endif

   always #5 clk = ~clk;

   axis_pgroup_sender #(
      .IP_AMT       (IPA),
      .IP_DATA_W    (DW),
      .AXIS_TID_W   (TIDW),
      .FRAME_BEATS  (FB),
      .BEATS_PER_IP (BPI)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start_i),
      .busy_o         (busy_o),
      .pgroup_i       (pgroup_i),
      .pgroup_valid_i (pgroup_valid_i),
      .pgroup_ready_o (pgroup_ready_o),
      .m_tid_o        (m_tid_o),
      .m_tdest_o      (m_tdest_o),
      .m_tdata_o      (m_tdata_o),
      .m_tkeep_o      (m_tkeep_o),
      .m_tstrb_o      (m_tstrb_o),
      .m_tlast_o      (m_tlast_o),
      .m_tvalid_o     (m_tvalid_o),
      .m_tready_i     (m_tready_i)
`ifdef AXIS_PGROUP_SENDER_STATS_EN
      ,
      .stall_cnt_o    (stall_cnt_o)
`endif
   );

   typedef struct {
      logic [DW-1:0]   data;
      logic [TIDW-1:0] tid;
      logic [TDW-1:0]  tdest;
      logic            tlast;
   } exp_t;

   typedef struct {
      int nfr;
      int vpct;
      int rmode;
      bit mid_start;
      bit idle_valid;
      int exp_beats;
   } scen_t;

   exp_t           expq[$];
   int             n_pass  = 0;
   int             n_total = 0;
   bit             in_frame;
   int             beat_m;
   int             frame_m;
   int             out_cnt;
   int             cyc;
   longint         stall_m;
   bit             stall_prev;
   logic [DW+4:0]  held;
   scen_t          scen[5];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic fail(input string nm);
      n_total++;
      $display("FAIL %s: condition not met (cycle %0d)", nm, cyc);
   endtask

   function automatic logic tready_for(input int rmode);
      case (rmode)
         0:       return 1'b1;
         1:       return (cyc % 3) == 0;
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic model_reset();
      expq.delete();
      in_frame   = 1'b0;
      beat_m     = 0;
      frame_m    = 0;
      stall_m    = 0;
      stall_prev = 1'b0;
   endtask

   // One clock: inputs already driven at the falling edge; check, then advance the model
   task automatic cycle();
      exp_t          e;
      int            qn;
      bit            busy_m;
      logic [DW+4:0] pay;
      #1;
      qn     = expq.size();
      busy_m = in_frame || (qn != 0);
      pay    = {m_tid_o, m_tdest_o, m_tlast_o, m_tdata_o};
      chk("busy", 64'(busy_o), 64'(busy_m));
      chk("tvalid", 64'(m_tvalid_o), 64'(qn != 0));
      chk("ready", 64'(pgroup_ready_o), 64'(in_frame && qn < 2));
`ifdef AXIS_PGROUP_SENDER_STATS_EN
      chk("stall_cnt", 64'(stall_cnt_o), 64'(stall_m));
`endif
      if (stall_prev) chk("hold_payload", 64'(pay), 64'(held));
      if (m_tvalid_o && m_tready_i) begin
         if (qn == 0) fail("spurious_beat");
         else begin
            e = expq.pop_front();
            chk("tdata", 64'(m_tdata_o), 64'(e.data));
            chk("tid", 64'(m_tid_o), 64'(e.tid));
            chk("tdest", 64'(m_tdest_o), 64'(e.tdest));
            chk("tlast", 64'(m_tlast_o), 64'(e.tlast));
            out_cnt++;
         end
      end
      stall_prev = m_tvalid_o && !m_tready_i;
      held       = pay;
      if (start_i && !busy_m) stall_m = 0;
      else if (qn != 0 && !m_tready_i) stall_m++;
      if (pgroup_valid_i && pgroup_ready_o) begin
         if (!in_frame) fail("idle_accept");
         else begin
            e.data  = pgroup_i;
            e.tid   = TIDW'(frame_m % (1 << TIDW));
            e.tdest = TDW'((beat_m / BPI) % IPA);
            e.tlast = ((beat_m % BPI) == BPI - 1) || (beat_m == FB - 1);
            expq.push_back(e);
            beat_m++;
            if (beat_m == FB) begin
               in_frame = 1'b0;
               beat_m   = 0;
               frame_m++;
            end
         end
      end
      if (start_i && !busy_m) begin
         in_frame = 1'b1;
         beat_m   = 0;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_start(input bit idle_valid, input int rmode);
      int n = 0;
      start_i        = 1'b1;
      pgroup_valid_i = idle_valid;
      while (!in_frame && n < 200) begin
         pgroup_i   = $urandom;
         m_tready_i = tready_for(rmode);
         cycle();
         n++;
      end
      if (!in_frame) fail("start_timeout");
      start_i = 1'b0;
   endtask

   task automatic stream(input int vpct, input int rmode, input bit mid_start);
      int n = 0;
      while (in_frame && n < 2000) begin
         pgroup_valid_i = ($urandom_range(0, 99) < vpct);
         pgroup_i       = $urandom;
         m_tready_i     = tready_for(rmode);
         start_i        = mid_start && (beat_m == 3 || beat_m == FB - 1);
         cycle();
         n++;
      end
      if (in_frame) fail("frame_timeout");
      start_i        = 1'b0;
      pgroup_valid_i = 1'b0;
   endtask

   task automatic drain(input int rmode);
      int n = 0;
      pgroup_valid_i = 1'b0;
      while (expq.size() != 0 && n < 200) begin
         m_tready_i = tready_for(rmode);
         cycle();
         n++;
      end
      if (expq.size() != 0) fail("drain_timeout");
      m_tready_i = 1'b1;
      cycle();
   endtask

   task automatic run_scen(input scen_t s);
      int out_start = out_cnt;
      for (int f = 0; f < s.nfr; f++) begin
         do_start(s.idle_valid, s.rmode);
         stream(s.vpct, s.rmode, s.mid_start);
      end
      drain(s.rmode);
      chk("beats_out", 64'(out_cnt - out_start), 64'(s.exp_beats));
   endtask

   task automatic check_reset_vals();
      chk("rst_tvalid", 64'(m_tvalid_o), 64'd0);
      chk("rst_tlast", 64'(m_tlast_o), 64'd0);
      chk("rst_tid", 64'(m_tid_o), 64'd0);
      chk("rst_tdest", 64'(m_tdest_o), 64'd0);
      chk("rst_tdata", 64'(m_tdata_o), 64'd0);
      chk("rst_ready", 64'(pgroup_ready_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
`ifdef AXIS_PGROUP_SENDER_STATS_EN
      chk("rst_stall", 64'(stall_cnt_o), 64'd0);
`endif
   endtask

   initial begin
      int n;
      scen[0] = '{1, 100, 0, 1'b0, 1'b0, 9};   // routing and framing
      scen[1] = '{5, 100, 0, 1'b0, 1'b0, 45};  // back-to-back frames, TID wrap
      scen[2] = '{2, 100, 1, 1'b0, 1'b0, 18};  // 1-on/2-off back-pressure
      scen[3] = '{2, 100, 0, 1'b1, 1'b1, 18};  // ignored start, input while idle
      scen[4] = '{3, 60, 2, 1'b0, 1'b0, 27};   // random valid and ready

      rst_n          = 1'b0;
      start_i        = 1'b0;
      pgroup_i       = '0;
      pgroup_valid_i = 1'b0;
      m_tready_i     = 1'b1;
      cyc            = 0;
      out_cnt        = 0;
      model_reset();
      #1;
      check_reset_vals();
      chk("tkeep", 64'(m_tkeep_o), 64'hF);
      chk("tstrb", 64'(m_tstrb_o), 64'hF);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 5; i++) run_scen(scen[i]);

      // Reset in the middle of a frame, after beat 3 is accepted
      do_start(1'b0, 0);
      n = 0;
      pgroup_valid_i = 1'b1;
      while (beat_m < 4 && n < 100) begin
         pgroup_i = $urandom;
         cycle();
         n++;
      end
      pgroup_valid_i = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      run_scen(scen[0]);

`ifdef AXIS_PGROUP_SENDER_STATS_EN
      // Hold one beat against a stalled sink for seven cycles
      do_start(1'b0, 0);
      m_tready_i     = 1'b0;
      pgroup_valid_i = 1'b1;
      pgroup_i       = $urandom;
      cycle();
      pgroup_valid_i = 1'b0;
      for (int i = 0; i < 7; i++) cycle();
      #1;
      chk("stall_7", 64'(stall_cnt_o), 64'd7);
      stream(100, 0, 1'b0);
      drain(0);
      do_start(1'b0, 0);
      #1;
      chk("stall_clear", 64'(stall_cnt_o), 64'd0);
      stream(100, 0, 1'b0);
      drain(0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
